// File: rtl/jam_pkg.sv
// Shared types and constants for the job-assignment cost server.
package jam_pkg;

  localparam int N_WORKERS = 8;
  localparam int COST_W    = 7;
  localparam int SUM_W     = 10;
  localparam int CNT_W     = 20;
  localparam int IDX_W     = $clog2(N_WORKERS * N_WORKERS);

  typedef enum logic [1:0] {
    LOAD,
    SERVE,
    DONE
  } jam_state_e;

endpackage

// File: rtl/jam_cost_mem.sv
// 64-entry cost register file: one write port, one registered read port.
module jam_cost_mem
  import jam_pkg::*;
#(
  parameter int COST_W = jam_pkg::COST_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [COST_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [COST_W-1:0] rdata
);

  // Contents survive reset; every entry is rewritten before it can be read.
  logic [COST_W-1:0] mem [2**IDX_W];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/jam_cost_server.sv
// Loads the 8x8 cost table, holds the engine in reset until it is full, then
// serves W/J lookups and captures the engine's single result strobe.
module jam_cost_server
  import jam_pkg::*;
#(
  parameter int COST_W = jam_pkg::COST_W,
  parameter int CNT_W  = jam_pkg::CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_valid,
  input  logic [COST_W-1:0] load_data,
  output logic              load_ready,
  output logic              JAM_RST,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  input  logic              Valid,
  input  logic [SUM_W-1:0]  MinCost,
  input  logic [3:0]        MatchCount,
  output logic              table_ready,
  output logic              result_valid,
  output logic [SUM_W-1:0]  result_min,
  output logic [3:0]        result_count,
  output logic              result_overrun,
  output logic [CNT_W-1:0]  serve_cycles
);

  jam_state_e       state_q, state_d;
  logic [IDX_W-1:0] ld_idx;
  logic             accept;
  logic             last_beat;

  // Load handshake: a beat transfers on any rising edge where load_valid and
  // load_ready are both high; load_ready is high only in LOAD outside reset.
  assign load_ready = (state_q == LOAD) && !RST;
  assign accept     = load_valid && load_ready;
  assign last_beat  = accept && (ld_idx == IDX_W'(2**IDX_W - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (last_beat) state_d = SERVE;
      SERVE:   if (Valid)     state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= LOAD;
      ld_idx         <= '0;
      JAM_RST        <= 1'b1;
      table_ready    <= 1'b0;
      result_valid   <= 1'b0;
      result_min     <= '0;
      result_count   <= '0;
      result_overrun <= 1'b0;
      serve_cycles   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) ld_idx <= ld_idx + 1'b1;
      if (last_beat) begin
        JAM_RST     <= 1'b0;
        table_ready <= 1'b1;
      end
      if (state_q == SERVE) begin
        if (serve_cycles != '1) serve_cycles <= serve_cycles + 1'b1;
        if (Valid) begin
          result_min   <= MinCost;
          result_count <= MatchCount;
          result_valid <= 1'b1;
        end
      end
      if (state_q == DONE && Valid) result_overrun <= 1'b1;
    end
  end

  // Lookups run in SERVE and DONE so a late engine read still gets an answer.
  jam_cost_mem #(.COST_W(COST_W)) u_mem (
    .CLK   (CLK),
    .RST   (RST),
    .we    (accept),
    .waddr (ld_idx),
    .wdata (load_data),
    .re    (state_q != LOAD),
    .raddr ({W, J}),
    .rdata (Cost)
  );

endmodule

// File: tb/tb_jam_cost_server.sv
// Bench for jam_cost_server: table vectors and a lookup scoreboard against a
// bench-side copy of the loaded cost table.
module tb_jam_cost_server;
  import jam_pkg::*;

  localparam int CW = 7;
  localparam int NW = 20;

  logic          CLK = 1'b0;
  logic          RST;
  logic          load_valid;
  logic [CW-1:0] load_data;
  logic          load_ready;
  logic          JAM_RST;
  logic [2:0]    W, J;
  logic [CW-1:0] Cost;
  logic          Valid;
  logic [9:0]    MinCost;
  logic [3:0]    MatchCount;
  logic          table_ready;
  logic          result_valid;
  logic [9:0]    result_min;
  logic [3:0]    result_count;
  logic          result_overrun;
  logic [NW-1:0] serve_cycles;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] model_mem[64];

  typedef struct {
    logic [2:0]    w;
    logic [2:0]    j;
    logic [CW-1:0] cost;
  } vec_t;
  vec_t vecs[6];

  always #5 CLK = ~CLK;

  jam_cost_server #(.COST_W(CW), .CNT_W(NW)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_ready     (load_ready),
    .JAM_RST        (JAM_RST),
    .W              (W),
    .J              (J),
    .Cost           (Cost),
    .Valid          (Valid),
    .MinCost        (MinCost),
    .MatchCount     (MatchCount),
    .table_ready    (table_ready),
    .result_valid   (result_valid),
    .result_min     (result_min),
    .result_count   (result_count),
    .result_overrun (result_overrun),
    .serve_cycles   (serve_cycles)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic load_beat(input logic [CW-1:0] d, input int gap);
    load_valid = 1'b0;
    repeat (gap) tick();
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic lookup(input string name, input logic [2:0] w, input logic [2:0] j);
    logic [CW-1:0] e;
    W = w;
    J = j;
    exp_q.push_back(model_mem[{w, j}]);
    tick();
    e = exp_q.pop_front();
    check(name, 32'(Cost), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{w: 3'd3, j: 3'd5, cost: 7'd29};
    vecs[1] = '{w: 3'd7, j: 3'd7, cost: 7'd63};
    vecs[2] = '{w: 3'd0, j: 3'd0, cost: 7'd0};
    vecs[3] = '{w: 3'd0, j: 3'd7, cost: 7'd7};
    vecs[4] = '{w: 3'd7, j: 3'd0, cost: 7'd56};
    vecs[5] = '{w: 3'd4, j: 3'd2, cost: 7'd34};

    RST = 1'b1; load_valid = 1'b0; load_data = '0;
    W = '0; J = '0; Valid = 1'b0; MinCost = '0; MatchCount = '0;
    tick();
    tick();
    check("rst_load_ready", 32'(load_ready), 0);
    RST = 1'b0;
    #1;
    check("post_rst_load_ready", 32'(load_ready), 1);
    check("rst_jam_rst", 32'(JAM_RST), 1);
    check("rst_cost", 32'(Cost), 0);
    check("rst_table_ready", 32'(table_ready), 0);
    check("rst_result_valid", 32'(result_valid), 0);
    check("rst_result_min", 32'(result_min), 0);
    check("rst_result_count", 32'(result_count), 0);
    check("rst_overrun", 32'(result_overrun), 0);
    check("rst_serve_cycles", 32'(serve_cycles), 0);

    // Engine activity while loading must be ignored.
    for (int i = 0; i < 5; i++) begin
      Valid = 1'b1;
      MinCost = 10'($urandom_range(0, 1023));
      W = 3'($urandom_range(0, 7));
      J = 3'($urandom_range(0, 7));
      tick();
      check("load_ignore_cost", 32'(Cost), 0);
      check("load_ignore_valid", 32'(result_valid), 0);
    end
    Valid = 1'b0;

    // Index table, back-to-back beats.
    for (int k = 0; k < 64; k++) begin
      model_mem[k] = CW'(k);
      if (k == 63) check("jam_rst_before_last", 32'(JAM_RST), 1);
      load_beat(CW'(k), 0);
    end
    check("jam_rst_after_last", 32'(JAM_RST), 0);
    check("table_ready_after_last", 32'(table_ready), 1);
    check("load_ready_serve", 32'(load_ready), 0);
    for (int i = 0; i < 6; i++) begin
      W = vecs[i].w;
      J = vecs[i].j;
      exp_q.push_back(vecs[i].cost);
      tick();
      check("vec_cost", 32'(Cost), 32'(exp_q.pop_front()));
    end

    // Gapped load after a reset from SERVE.
    pulse_reset();
    check("reset_serve_jam_rst", 32'(JAM_RST), 1);
    check("reset_serve_table_ready", 32'(table_ready), 0);
    for (int k = 0; k < 64; k++) begin
      if (k == 63) check("gap_table_ready_early", 32'(table_ready), 0);
      load_beat(CW'(k), 1);
    end
    check("gap_table_ready", 32'(table_ready), 1);
    lookup("gap_w7j7", 3'd7, 3'd7);
    for (int i = 0; i < 8; i++)
      lookup("gap_rand", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    // Reset mid-load, then a full table of 127s.
    pulse_reset();
    for (int k = 0; k < 30; k++) load_beat(CW'($urandom_range(0, 100)), 0);
    pulse_reset();
    for (int k = 0; k < 64; k++) begin
      model_mem[k] = 7'd127;
      if (k == 63) check("midrst_table_ready_early", 32'(table_ready), 0);
      load_beat(7'd127, 0);
    end
    check("midrst_table_ready", 32'(table_ready), 1);

    // Result capture after 1000 serve cycles.
    repeat (999) tick();
    Valid = 1'b1; MinCost = 10'd435; MatchCount = 4'd3;
    tick();
    Valid = 1'b0;
    check("cap_result_valid", 32'(result_valid), 1);
    check("cap_result_min", 32'(result_min), 435);
    check("cap_result_count", 32'(result_count), 3);
    check("cap_serve_cycles", 32'(serve_cycles), 1000);
    check("cap_overrun", 32'(result_overrun), 0);
    repeat (5) tick();
    check("done_serve_frozen", 32'(serve_cycles), 1000);

    Valid = 1'b1; MinCost = 10'd12; MatchCount = 4'd9;
    tick();
    Valid = 1'b0;
    check("overrun_set", 32'(result_overrun), 1);
    check("overrun_min_kept", 32'(result_min), 435);
    check("overrun_count_kept", 32'(result_count), 3);
    for (int k = 0; k < 64; k++) lookup("done_all_127", 3'(k >> 3), 3'(k & 7));

    pulse_reset();
    check("reset_done_jam_rst", 32'(JAM_RST), 1);
    check("reset_done_result_valid", 32'(result_valid), 0);
    check("reset_done_result_min", 32'(result_min), 0);
    check("reset_done_overrun", 32'(result_overrun), 0);
    check("reset_done_serve_cycles", 32'(serve_cycles), 0);
    check("reset_done_cost", 32'(Cost), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
